// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM memory port arbiter: FSM encoding, grant ids
// and the DMType word code used for instruction fetches.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // DMType control code for a full 32-bit word access
    localparam logic [2:0] DMT_WORD = 3'b000;

endpackage

// File: rtl/mem_arb_timeout.sv
// Busy-cycle counter for the memory arbiter; flags expiry on the
// TIMEOUT_CYCLES-th busy cycle without an ack. TIMEOUT_CYCLES=0 never expires.
module mem_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Clears whenever the access ends, so the next access always starts at 0
    always_comb begin
        cnt_d = '0;
        if (busy && !ack && !expired) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_to
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            assign expired = busy && (cnt_q == LAST);
        end else begin : g_no_to
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both sides contend.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AW             = 32,
    parameter int DW             = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [2:0]    dm_type,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_type,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]    mem_type_q, mem_type_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          busy, expired, grant_dm;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

    mem_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .ack     (mem_ack),
        .expired (expired)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign grant_dm = dm_req && (!if_req || (last_grant_q == GRANT_IF));

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (dm_req || if_req))
            last_grant_d = grant_dm ? GRANT_DM : GRANT_IF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant_q <= GRANT_IF;
        else      last_grant_q <= last_grant_d;
    end
`else
    assign grant_dm = dm_req;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_type_d  = dm_type;
                end else if (if_req) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_type_d  = DMT_WORD;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // An ack on the expiry cycle still completes the access normally
                if (mem_ack || expired) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = err_q | !mem_ack;
                    if (state_q == BUSY_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_type  = mem_type_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (TIMEOUT_CYCLES=8): one
// table row per clock, plus a hand-written asynchronous reset sequence.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [2:0]  dm_type;
        logic        mem_ack;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [2:0]  mem_type;
        logic        if_ready;
        logic [31:0] if_rdata;
        logic        dm_ready;
        logic [31:0] dm_rdata;
        logic        err;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [2:0]  dm_type;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we, err;
    logic [2:0]  mem_type;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_type(dm_type), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    function automatic in_t vi(logic r, logic ir, logic [31:0] ia, logic dr, logic dwe,
                               logic [31:0] da, logic [31:0] dwd, logic [2:0] dt,
                               logic ack, logic [31:0] mrd);
        vi = {r, ir, ia, dr, dwe, da, dwd, dt, ack, mrd};
    endfunction

    function automatic out_t vo(logic mreq, logic mwe, logic [31:0] maddr, logic [31:0] mwd,
                                logic [2:0] mt, logic irdy, logic [31:0] ird, logic drdy,
                                logic [31:0] drd, logic e);
        vo = {mreq, mwe, maddr, mwd, mt, irdy, ird, drdy, drd, e};
    endfunction

    function automatic string fmt(out_t o);
        fmt = $sformatf("req=%0b we=%0b addr=%h wd=%h ty=%0d ifr=%0b ifd=%h dmr=%0b dmd=%h err=%0b",
                        o.mem_req, o.mem_we, o.mem_addr, o.mem_wdata, o.mem_type,
                        o.if_ready, o.if_rdata, o.dm_ready, o.dm_rdata, o.err);
    endfunction

    task automatic add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n; v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    task automatic drive(in_t i);
        rst = i.rst; if_req = i.if_req; if_addr = i.if_addr;
        dm_req = i.dm_req; dm_we = i.dm_we; dm_addr = i.dm_addr;
        dm_wdata = i.dm_wdata; dm_type = i.dm_type;
        mem_ack = i.mem_ack; mem_rdata = i.mem_rdata;
    endtask

    task automatic chk(string n, out_t exp);
        out_t act;
        act = {mem_req, mem_we, mem_addr, mem_wdata, mem_type,
               if_ready, if_rdata, dm_ready, dm_rdata, err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {%s} expected {%s}", n, fmt(act), fmt(exp));
        end
    endtask

    task automatic chk_bit(string n, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a fetch pending: everything stays zero
        for (int k = 0; k < 3; k++)
            add("rst_hold", vi(0,1,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0));
        add("if_grant",  vi(1,1,0,0,0,0,0,0,0,0),    vo(1,0,0,0,0,0,0,0,0,0));
        add("if_wait",   vi(1,1,0,0,0,0,0,0,0,0),    vo(1,0,0,0,0,0,0,0,0,0));
        add("if_ack",    vi(1,1,0,0,0,0,0,0,1,'h13), vo(0,0,0,0,0,1,'h13,0,0,0));
        add("if_resp",   vi(1,1,0,0,0,0,0,0,0,0),    vo(0,0,0,0,0,0,'h13,0,0,0));
        add("idle",      vi(1,0,0,0,0,0,0,0,0,0),    vo(0,0,0,0,0,0,'h13,0,0,0));
        // Simultaneous store and fetch: the store wins
        add("cf_grant",  vi(1,1,4,1,1,'h100,'hDEADBEEF,2,0,0),     vo(1,1,'h100,'hDEADBEEF,2,0,'h13,0,0,0));
        add("cf_st_ack", vi(1,1,4,1,1,'h100,'hDEADBEEF,2,1,'h55),  vo(0,1,'h100,'hDEADBEEF,2,0,'h13,1,0,0));
        add("cf_resp",   vi(1,1,4,1,1,'h100,'hDEADBEEF,2,0,0),     vo(0,1,'h100,'hDEADBEEF,2,0,'h13,0,0,0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        add("p2_if_grant", vi(1,1,4,1,0,'h104,0,2,0,0),            vo(1,0,4,0,0,0,'h13,0,0,0));
        add("p2_if_ack",   vi(1,1,4,1,0,'h104,0,2,1,'h00100073),   vo(0,0,4,0,0,1,'h00100073,0,0,0));
        add("p2_if_resp",  vi(1,1,4,1,0,'h104,0,2,0,0),            vo(0,0,4,0,0,0,'h00100073,0,0,0));
        add("p2_dm_grant", vi(1,0,0,1,0,'h104,0,2,0,0),            vo(1,0,'h104,0,2,0,'h00100073,0,0,0));
        add("p2_dm_ack",   vi(1,0,0,1,0,'h104,0,2,1,'h0BADF00D),   vo(0,0,'h104,0,2,0,'h00100073,1,'h0BADF00D,0));
        add("p2_dm_resp",  vi(1,0,0,1,0,'h104,0,2,0,0),            vo(0,0,'h104,0,2,0,'h00100073,0,'h0BADF00D,0));
`else
        add("p2_dm_grant", vi(1,1,4,1,0,'h104,0,2,0,0),            vo(1,0,'h104,0,2,0,'h13,0,0,0));
        add("p2_dm_ack",   vi(1,1,4,1,0,'h104,0,2,1,'h0BADF00D),   vo(0,0,'h104,0,2,0,'h13,1,'h0BADF00D,0));
        add("p2_dm_resp",  vi(1,1,4,1,0,'h104,0,2,0,0),            vo(0,0,'h104,0,2,0,'h13,0,'h0BADF00D,0));
        add("p2_if_grant", vi(1,1,4,0,0,0,0,0,0,0),                vo(1,0,4,0,0,0,'h13,0,'h0BADF00D,0));
        add("p2_if_ack",   vi(1,1,4,0,0,0,0,0,1,'h00100073),       vo(0,0,4,0,0,1,'h00100073,0,'h0BADF00D,0));
        add("p2_if_resp",  vi(1,1,4,0,0,0,0,0,0,0),                vo(0,0,4,0,0,0,'h00100073,0,'h0BADF00D,0));
`endif
        // Load with ack on the 5th busy cycle; requester changes while busy are ignored
        add("ld_grant",  vi(1,0,0,1,0,'h200,0,2,0,0),                vo(1,0,'h200,0,2,0,'h00100073,0,'h0BADF00D,0));
        add("ld_ignore", vi(1,1,'h44,1,1,'h999,'hFFFFFFFF,7,0,0),    vo(1,0,'h200,0,2,0,'h00100073,0,'h0BADF00D,0));
        for (int k = 0; k < 3; k++)
            add("ld_wait", vi(1,0,0,1,0,'h200,0,2,0,0),              vo(1,0,'h200,0,2,0,'h00100073,0,'h0BADF00D,0));
        add("ld_ack",    vi(1,0,0,1,0,'h200,0,2,1,'h12345678),       vo(0,0,'h200,0,2,0,'h00100073,1,'h12345678,0));
        add("ld_resp",   vi(1,0,0,1,0,'h200,0,2,0,0),                vo(0,0,'h200,0,2,0,'h00100073,0,'h12345678,0));
        add("ld_idle",   vi(1,0,0,0,0,0,0,0,0,0),                    vo(0,0,'h200,0,2,0,'h00100073,0,'h12345678,0));
        // Fetch with no ack: aborts on the 8th busy cycle
        add("to_grant",  vi(1,1,'h40,0,0,0,0,0,0,0),                 vo(1,0,'h40,0,0,0,'h00100073,0,'h12345678,0));
        for (int k = 0; k < 7; k++)
            add("to_wait", vi(1,1,'h40,0,0,0,0,0,0,0),               vo(1,0,'h40,0,0,0,'h00100073,0,'h12345678,0));
        add("to_expire", vi(1,1,'h40,0,0,0,0,0,0,0),                 vo(0,0,'h40,0,0,1,0,0,'h12345678,1));
        add("to_resp",   vi(1,1,'h40,0,0,0,0,0,0,0),                 vo(0,0,'h40,0,0,0,0,0,'h12345678,1));
        add("err_stick", vi(1,0,0,0,0,0,0,0,0,0),                    vo(0,0,'h40,0,0,0,0,0,'h12345678,1));
        add("late_ack",  vi(1,0,0,0,0,0,0,0,1,'hFFFF),               vo(0,0,'h40,0,0,0,0,0,'h12345678,1));
        add("err_clear", vi(0,0,0,0,0,0,0,0,0,0),                    vo(0,0,0,0,0,0,0,0,0,0));
        // Ack on the very cycle the timeout would fire
        add("ak_grant",  vi(1,1,'h80,0,0,0,0,0,0,0),                 vo(1,0,'h80,0,0,0,0,0,0,0));
        for (int k = 0; k < 7; k++)
            add("ak_wait", vi(1,1,'h80,0,0,0,0,0,0,0),               vo(1,0,'h80,0,0,0,0,0,0,0));
        add("ak_on_to",  vi(1,1,'h80,0,0,0,0,0,1,'hA5A5A5A5),        vo(0,0,'h80,0,0,1,'hA5A5A5A5,0,0,0));
        add("ak_resp",   vi(1,1,'h80,0,0,0,0,0,1,'hFFFFFFFF),        vo(0,0,'h80,0,0,0,'hA5A5A5A5,0,0,0));
        add("ak_idle",   vi(1,0,0,0,0,0,0,0,0,0),                    vo(0,0,'h80,0,0,0,'hA5A5A5A5,0,0,0));

        drive(vi(0,0,0,0,0,0,0,0,0,0));
        foreach (tbl[n]) begin
            @(negedge clk);
            drive(tbl[n].i);
            @(posedge clk);
            #1;
            chk(tbl[n].name, tbl[n].o);
        end

        // Reset in the middle of a data access drops mem_req immediately
        @(negedge clk);
        drive(vi(1,0,0,1,0,'h300,0,2,0,0));
        @(posedge clk); #1;
        chk_bit("mr_grant", mem_req, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk_bit("mr_async_req", mem_req, 1'b0);
        chk_bit("mr_async_addr", mem_addr == 32'h0, 1'b1);
        @(negedge clk);
        drive(vi(1,0,0,0,0,0,0,0,1,'hFFFFFFFF));
        @(posedge clk); #1;
        chk("stale_ack", vo(0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        drive(vi(1,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        chk("post_rst_idle", vo(0,0,0,0,0,0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
